tug_of_war_match: RTL

- Parametrised best-of-N tug-of-war match engine; successor to the fixed 9-light, single-round game top.
- Generalises the playfield to NUM_LEDS lights.
- Adds a human-vs-human mode, a rate-limited LFSR computer opponent, an inter-round gap and a match-over state.
- Sits between the debounced board keys/switches and the LED/HEX display logic.

---
 rtl/tug_of_war_match.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/tug_of_war_match.sv
// -----------------------------------------------------------------------------
// tug_of_war_match
//
// Best-of-N tug-of-war match engine. Two players pull a one-hot "rope"
// position across NUM_LEDS lights. Reaching the far end on your side scores
// a point. After each point there is a short dead gap, then the rope returns
// to the centre. The first player to WIN_SCORE points wins the match, and
// the engine then holds in a match-over state until reset.
//
// The left player is either a second human (mode=1) or a rate-limited LFSR
// computer opponent (mode=0) whose press probability is set by sw_level.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset (0 = reset)
//   key_r      right-player button, raw, active-low
//   key_l      left-player button, raw, active-low (used only when mode=1)
//   mode       0 = human (right) vs computer (left), 1 = human vs human
//   sw_level   computer strength; higher values press more often
//   led        one-hot rope position, led[NUM_LEDS-1] is leftmost;
//              all zero during the gap, all ones when the match is over
//   score_l    left points
//   score_r    right points
//   match_over high once a player has reached WIN_SCORE
//   winner     0 = left, 1 = right; meaningful only while match_over=1
//
// Press handshake: each key produces a single-cycle press pulse on the
// synchronised 1->0 transition. A pulse is consumed in the cycle it is high;
// there is no back-pressure, so a pulse arriving in GAP or OVER is dropped.
// -----------------------------------------------------------------------------
module tug_of_war_match #(
    parameter int NUM_LEDS    = 9,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int LFSR_W      = 10,
    parameter int CPU_DIV     = 16,
    parameter int GAP_CYCLES  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_r,
    input  logic                key_l,
    input  logic                mode,
    input  logic [LFSR_W-1:0]   sw_level,
    output logic [NUM_LEDS-1:0] led,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r,
    output logic                match_over,
    output logic                winner
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int DIV_W = $clog2(CPU_DIV + 1);

    localparam logic [POS_W-1:0]    POS_C      = POS_W'((NUM_LEDS - 1) / 2);
    localparam logic [POS_W-1:0]    POS_MAX    = POS_W'(NUM_LEDS - 1);
    localparam logic [SCORE_W-1:0]  WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(CPU_DIV - 1);
    localparam logic [NUM_LEDS-1:0] LED_CENTRE = NUM_LEDS'(1) << POS_C;

    // Maximal-length Fibonacci tap sets (1-based tap positions) by width.
    function automatic logic [31:0] tap_mask(input int w);
        logic [31:0] m;
        m = 32'd0;
        case (w)
            2:       m = (32'd1 << 1) | (32'd1 << 0);
            3:       m = (32'd1 << 2) | (32'd1 << 1);
            4:       m = (32'd1 << 3) | (32'd1 << 2);
            5:       m = (32'd1 << 4) | (32'd1 << 2);
            6:       m = (32'd1 << 5) | (32'd1 << 4);
            7:       m = (32'd1 << 6) | (32'd1 << 5);
            8:       m = (32'd1 << 7) | (32'd1 << 5) | (32'd1 << 4) | (32'd1 << 3);
            9:       m = (32'd1 << 8) | (32'd1 << 4);
            10:      m = (32'd1 << 9) | (32'd1 << 6);
            11:      m = (32'd1 << 10) | (32'd1 << 8);
            12:      m = (32'd1 << 11) | (32'd1 << 5) | (32'd1 << 3) | (32'd1 << 0);
            13:      m = (32'd1 << 12) | (32'd1 << 3) | (32'd1 << 2) | (32'd1 << 0);
            14:      m = (32'd1 << 13) | (32'd1 << 4) | (32'd1 << 2) | (32'd1 << 0);
            15:      m = (32'd1 << 14) | (32'd1 << 13);
            default: m = (32'd1 << 15) | (32'd1 << 14) | (32'd1 << 12) | (32'd1 << 3);
        endcase
        return m;
    endfunction

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(tap_mask(LFSR_W));

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_GAP  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // ---------------- key synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] r_sync_r, r_sync_l;
    logic                   r_prev_r, r_prev_l;
    logic                   r_press_r, r_press_l;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_r  <= '1;
            r_sync_l  <= '1;
            r_prev_r  <= 1'b1;
            r_prev_l  <= 1'b1;
            r_press_r <= 1'b0;
            r_press_l <= 1'b0;
        end else begin
            r_sync_r[0] <= key_r;
            r_sync_l[0] <= key_l;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_r[i] <= r_sync_r[i-1];
                r_sync_l[i] <= r_sync_l[i-1];
            end
            r_prev_r  <= r_sync_r[SYNC_STAGES-1];
            r_prev_l  <= r_sync_l[SYNC_STAGES-1];
            // Falling edge of the synchronised key: high for exactly one
            // cycle however long the key is held.
            r_press_r <= r_prev_r & ~r_sync_r[SYNC_STAGES-1];
            r_press_l <= r_prev_l & ~r_sync_l[SYNC_STAGES-1];
        end
    end

    // ---------------- computer opponent ----------------
    logic [LFSR_W-1:0] r_lfsr;
    logic [DIV_W-1:0]  r_div;
    logic              r_cpu_press;
    logic              w_lfsr_fb;

    assign w_lfsr_fb = ^(r_lfsr & TAPS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr      <= LFSR_W'(1);
            r_div       <= '0;
            r_cpu_press <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_lfsr_fb};
            if (r_div == DIV_LAST) begin
                r_div       <= '0;
                r_cpu_press <= (r_lfsr < sw_level);
            end else begin
                r_div       <= r_div + DIV_W'(1);
                r_cpu_press <= 1'b0;
            end
        end
    end

    // ---------------- match FSM ----------------
    state_t              r_state, w_state_n;
    logic [POS_W-1:0]    r_pos, w_pos_n;
    logic [GAP_W-1:0]    r_gap_cnt, w_gap_n;
    logic [SCORE_W-1:0]  r_score_l, r_score_r, w_score_l_n, w_score_r_n;
    logic                r_winner, w_winner_n;
    logic [NUM_LEDS-1:0] r_led, w_led_n;
    logic                r_match_over;
    logic                w_l, w_r;

    assign w_l = mode ? r_press_l : r_cpu_press;
    assign w_r = r_press_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_PLAY;
            r_pos        <= POS_C;
            r_gap_cnt    <= '0;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_winner     <= 1'b0;
            r_led        <= LED_CENTRE;
            r_match_over <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pos        <= w_pos_n;
            r_gap_cnt    <= w_gap_n;
            r_score_l    <= w_score_l_n;
            r_score_r    <= w_score_r_n;
            r_winner     <= w_winner_n;
            r_led        <= w_led_n;
            r_match_over <= (w_state_n == ST_OVER);
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_pos_n     = r_pos;
        w_gap_n     = r_gap_cnt;
        w_score_l_n = r_score_l;
        w_score_r_n = r_score_r;
        w_winner_n  = r_winner;
        w_led_n     = '0;

        case (r_state)
            ST_PLAY: begin
                if (w_l && !w_r) begin
                    if (r_pos == POS_MAX) begin
                        w_score_l_n = r_score_l + SCORE_W'(1);
                        w_pos_n     = POS_C;
                        w_gap_n     = '0;
                        if (w_score_l_n == WIN) begin
                            w_state_n  = ST_OVER;
                            w_winner_n = 1'b0;
                        end else begin
                            w_state_n  = ST_GAP;
                        end
                    end else begin
                        w_pos_n = r_pos + POS_W'(1);
                    end
                end else if (w_r && !w_l) begin
                    if (r_pos == '0) begin
                        w_score_r_n = r_score_r + SCORE_W'(1);
                        w_pos_n     = POS_C;
                        w_gap_n     = '0;
                        if (w_score_r_n == WIN) begin
                            w_state_n  = ST_OVER;
                            w_winner_n = 1'b1;
                        end else begin
                            w_state_n  = ST_GAP;
                        end
                    end else begin
                        w_pos_n = r_pos - POS_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_n = ST_PLAY;
                    w_gap_n   = '0;
                    w_pos_n   = POS_C;
                end else begin
                    w_gap_n = r_gap_cnt + GAP_W'(1);
                end
            end
            ST_OVER: begin
                // Frozen until reset.
            end
            default: begin
                w_state_n = ST_PLAY;
                w_pos_n   = POS_C;
                w_gap_n   = '0;
            end
        endcase

        // The display is registered from the next-state values so it
        // changes on the same edge as the state it reflects.
        case (w_state_n)
            ST_OVER: w_led_n = '1;
            ST_GAP:  w_led_n = '0;
            default: w_led_n = NUM_LEDS'(1) << w_pos_n;
        endcase
    end

    assign led        = r_led;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign match_over = r_match_over;
    assign winner     = r_winner;

endmodule
